otter_sig_dumper: RTL and testbench

- Synthesizable completion and signature-readout block for Otter compliance runs on hardware.
- Bus responder on the core's data-memory interface: exposes the TOHOST, SIG_START, SIG_END and STATUS registers.
- On a non-zero TOHOST write, becomes a read initiator on a synchronous word memory port. Walks the signature region word by word and streams each word out on a valid/ready interface, for example toward a UART framer.

---
 rtl/otter_sig_dumper.sv | 217 +++++++++++++++++++++
 tb/tb_otter_sig_dumper.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/otter_sig_dumper.sv
// otter_sig_dumper: TOHOST/signature register window plus signature-region streamer.
// Optional macro SIG_DUMP_HEADER_EN prefixes the stream with a word-count header.
`default_nettype none

module otter_sig_dumper #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MEM_EXP   = 28
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          dmem_addr,
  input  logic                 dmem_r_en,
  input  logic                 dmem_w_en,
  input  logic [3:0]           dmem_w_strb,
  input  logic [31:0]          dmem_w_data,
  output logic [31:0]          dev_r_data,
  output logic                 mem_r_en,
  output logic [MEM_EXP-3:0]   mem_addr,
  input  logic [31:0]          mem_r_data,
  output logic                 sig_valid,
  output logic [31:0]          sig_data,
  output logic                 sig_last,
  input  logic                 sig_ready,
  output logic                 done,
  output logic                 err,
  output logic [31:0]          tohost_code
);

  localparam int AW = MEM_EXP - 2;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CHECK = 3'd1;
`ifdef SIG_DUMP_HEADER_EN
  localparam logic [2:0] S_HDR   = 3'd2;
`endif
  localparam logic [2:0] S_REQ   = 3'd3;
  localparam logic [2:0] S_WAIT  = 3'd4;
  localparam logic [2:0] S_SEND  = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  logic [2:0]    r_state;
  logic [31:0]   r_tohost;
  logic [31:0]   r_sig_start;
  logic [31:0]   r_sig_end;
  logic [31:0]   r_code;
  logic [31:0]   r_dev_r_data;
  logic [AW-1:0] r_cur;
  logic [AW-1:0] r_end;
  logic          r_done;
  logic          r_err;
  logic          r_sig_valid;
  logic [31:0]   r_sig_data;
  logic          r_sig_last;

  logic          w_hit;
  logic          w_wr_hit;
  logic          w_rd_hit;
  logic          w_busy;
  logic          w_trigger;
  logic          w_misaligned;
  logic          w_next_last;
  logic [31:0]   w_tohost_next;
  logic [31:0]   w_status;
  logic [AW-1:0] w_cur_inc;
  logic [AW-1:0] w_count;
  logic          w_unused;

  function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                          input logic [31:0] new_v,
                                          input logic [3:0]  strb);
    logic [31:0] res;
    res = old_v;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = new_v[8*i +: 8];
    end
    return res;
  endfunction

  assign w_hit         = (dmem_addr[31:4] == BASE_ADDR[31:4]);
  assign w_wr_hit      = w_hit && dmem_w_en;
  assign w_rd_hit      = w_hit && dmem_r_en;
  assign w_busy        = (r_state != S_IDLE) && (r_state != S_DONE);
  assign w_tohost_next = f_merge(r_tohost, dmem_w_data, dmem_w_strb);
  assign w_trigger     = (r_state == S_IDLE) && w_wr_hit &&
                         (dmem_addr[3:2] == 2'd0) && (w_tohost_next != 32'd0);
  assign w_misaligned  = (r_sig_start[1:0] != 2'd0) || (r_sig_end[1:0] != 2'd0);
  assign w_cur_inc     = r_cur + 1'b1;
  assign w_next_last   = (w_cur_inc == r_end);
  assign w_count       = r_end - r_cur;
  assign w_status      = {29'd0, r_err, r_done, w_busy};
  // Only the word-address bits of the region registers and bus address are consumed.
  assign w_unused      = ^{dmem_addr[1:0], r_sig_start, r_sig_end, w_count};

  assign dev_r_data  = r_dev_r_data;
  assign mem_r_en    = (r_state == S_REQ);
  assign mem_addr    = r_cur;
  assign sig_valid   = r_sig_valid;
  assign sig_data    = r_sig_data;
  assign sig_last    = r_sig_last;
  assign done        = r_done;
  assign err         = r_err;
  assign tohost_code = r_code;

  // Register window: TOHOST is frozen once the dump has finished; region registers while busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tohost     <= 32'd0;
      r_sig_start  <= 32'd0;
      r_sig_end    <= 32'd0;
      r_dev_r_data <= 32'd0;
    end else begin
      if (w_wr_hit) begin
        case (dmem_addr[3:2])
          2'd0: if (r_state != S_DONE) r_tohost <= w_tohost_next;
          2'd1: if (!w_busy) r_sig_start <= f_merge(r_sig_start, dmem_w_data, dmem_w_strb);
          2'd2: if (!w_busy) r_sig_end <= f_merge(r_sig_end, dmem_w_data, dmem_w_strb);
          default: ;
        endcase
      end
      if (w_rd_hit) begin
        case (dmem_addr[3:2])
          2'd0:    r_dev_r_data <= r_tohost;
          2'd1:    r_dev_r_data <= r_sig_start;
          2'd2:    r_dev_r_data <= r_sig_end;
          default: r_dev_r_data <= w_status;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_code      <= 32'd0;
      r_cur       <= '0;
      r_end       <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_sig_valid <= 1'b0;
      r_sig_data  <= 32'd0;
      r_sig_last  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_trigger) begin
            r_code  <= w_tohost_next;
            r_cur   <= r_sig_start[MEM_EXP-1:2];
            r_end   <= r_sig_end[MEM_EXP-1:2];
            r_state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (w_misaligned || (r_end < r_cur)) begin
            r_err   <= 1'b1;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
`ifdef SIG_DUMP_HEADER_EN
          else begin
            r_sig_valid <= 1'b1;
            r_sig_data  <= 32'(w_count);
            r_sig_last  <= (r_end == r_cur);
            r_state     <= S_HDR;
          end
`else
          else if (r_end == r_cur) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_state <= S_REQ;
          end
`endif
        end
`ifdef SIG_DUMP_HEADER_EN
        S_HDR: begin
          if (sig_ready) begin
            r_sig_valid <= 1'b0;
            r_sig_last  <= 1'b0;
            if (r_sig_last) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_state <= S_REQ;
            end
          end
        end
`endif
        S_REQ: r_state <= S_WAIT;
        S_WAIT: begin
          // Memory data is only valid on this one cycle, so it is captured here.
          r_sig_valid <= 1'b1;
          r_sig_data  <= mem_r_data;
          r_sig_last  <= w_next_last;
          r_state     <= S_SEND;
        end
        S_SEND: begin
          if (sig_ready) begin
            r_sig_valid <= 1'b0;
            r_sig_last  <= 1'b0;
            r_cur       <= w_cur_inc;
            if (r_sig_last) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_state <= S_REQ;
            end
          end
        end
        S_DONE:  r_state <= S_DONE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_otter_sig_dumper.sv
// Bench for otter_sig_dumper: queue-based stream/request model plus directed scenarios.
`default_nettype none

module tb_otter_sig_dumper;
  localparam int          MEM_EXP = 28;
  localparam logic [31:0] BASE    = 32'h0000_0000;
`ifdef SIG_DUMP_HEADER_EN
  localparam int          HOFF    = 1;
`else
  localparam int          HOFF    = 0;
`endif

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [31:0]         dmem_addr = 32'd0;
  logic                dmem_r_en = 1'b0;
  logic                dmem_w_en = 1'b0;
  logic [3:0]          dmem_w_strb = 4'd0;
  logic [31:0]         dmem_w_data = 32'd0;
  logic [31:0]         dev_r_data;
  logic                mem_r_en;
  logic [MEM_EXP-3:0]  mem_addr;
  logic [31:0]         mem_r_data;
  logic                sig_valid;
  logic [31:0]         sig_data;
  logic                sig_last;
  logic                sig_ready = 1'b1;
  logic                done;
  logic                err;
  logic [31:0]         tohost_code;

  otter_sig_dumper #(.BASE_ADDR(BASE), .MEM_EXP(MEM_EXP)) dut (
    .clk(clk), .rst_n(rst_n),
    .dmem_addr(dmem_addr), .dmem_r_en(dmem_r_en), .dmem_w_en(dmem_w_en),
    .dmem_w_strb(dmem_w_strb), .dmem_w_data(dmem_w_data), .dev_r_data(dev_r_data),
    .mem_r_en(mem_r_en), .mem_addr(mem_addr), .mem_r_data(mem_r_data),
    .sig_valid(sig_valid), .sig_data(sig_data), .sig_last(sig_last), .sig_ready(sig_ready),
    .done(done), .err(err), .tohost_code(tohost_code)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;

  task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory image and synchronous read port.
  logic [31:0] mem [int];
  logic [31:0] A [4] = '{32'hA0A0_0001, 32'hA1A1_0002, 32'hA2A2_0003, 32'hA3A3_0004};

  function automatic logic [31:0] mem_word(input int idx);
    if (mem.exists(idx)) return mem[idx];
    return 32'hD00D_0000 ^ 32'(idx);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)        mem_r_data <= 32'd0;
    else if (mem_r_en) mem_r_data <= mem_word(int'(mem_addr));
    else               mem_r_data <= 32'hBAD0_BAD0;
  end

  // Model: expected requests and stream words, derived from the region bounds.
  logic [31:0] exp_words [$];
  int          exp_addrs [$];
  logic [31:0] rx_log    [$];
  bit          last_log  [$];
  int          req_log   [$];
  bit          exp_err;

  task automatic model_clear();
    exp_words.delete(); exp_addrs.delete();
    rx_log.delete(); last_log.delete(); req_log.delete();
    exp_err = 1'b0;
  endtask

  task automatic model_arm(input logic [31:0] s, input logic [31:0] e);
    int cur;
    int lim;
    model_clear();
    cur = int'(s[MEM_EXP-1:2]);
    lim = int'(e[MEM_EXP-1:2]);
    exp_err = (s[1:0] != 2'd0) || (e[1:0] != 2'd0) || (lim < cur);
    if (!exp_err) begin
`ifdef SIG_DUMP_HEADER_EN
      exp_words.push_back(32'(lim - cur));
`endif
      for (int a = cur; a < lim; a++) begin
        exp_addrs.push_back(a);
        exp_words.push_back(mem_word(a));
      end
    end
  endtask

  // Per-cycle compare against the model.
  bit          prev_stall = 1'b0;
  logic [31:0] prev_data  = 32'd0;
  logic        prev_last  = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_r_en) begin
        req_log.push_back(int'(mem_addr));
        if (exp_addrs.size() == 0) chk_eq("unexpected_mem_req", 32'(mem_addr), 32'hFFFF_FFFF);
        else chk_eq("mem_addr", 32'(mem_addr), 32'(exp_addrs.pop_front()));
      end
      if (prev_stall) begin
        chk_eq("hold_valid", 32'(sig_valid), 32'd1);
        chk_eq("hold_data", sig_data, prev_data);
        chk_eq("hold_last", 32'(sig_last), 32'(prev_last));
      end
      if (sig_valid && !sig_ready) chk_eq("no_req_in_stall", 32'(mem_r_en), 32'd0);
      if (sig_valid && sig_ready) begin
        rx_log.push_back(sig_data);
        last_log.push_back(sig_last);
        if (exp_words.size() == 0) chk_eq("unexpected_word", sig_data, 32'hFFFF_FFFF);
        else begin
          chk_eq("sig_last", 32'(sig_last), 32'(exp_words.size() == 1));
          chk_eq("sig_data", sig_data, exp_words.pop_front());
        end
      end
      prev_stall = sig_valid && !sig_ready;
      prev_data  = sig_data;
      prev_last  = sig_last;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // Bus and sequencing helpers; all are entered #1 after a rising edge.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    dmem_addr = a; dmem_w_data = d; dmem_w_strb = s; dmem_w_en = 1'b1;
    @(posedge clk); #1;
    dmem_w_en = 1'b0; dmem_w_strb = 4'd0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    dmem_addr = a; dmem_r_en = 1'b1;
    @(posedge clk); #1;
    dmem_r_en = 1'b0;
    d = dev_r_data;
  endtask

  task automatic do_reset(input bit check_outs);
    rst_n = 1'b0;
    model_clear();
    @(posedge clk); #1;
    if (check_outs) begin
      chk_eq("reset_ctrl", {27'd0, sig_valid, sig_last, done, err, mem_r_en}, 32'd0);
      chk_eq("reset_sig_data", sig_data, 32'd0);
      chk_eq("reset_tohost_code", tohost_code, 32'd0);
      chk_eq("reset_dev_r_data", dev_r_data, 32'd0);
      chk_eq("reset_mem_addr", 32'(mem_addr), 32'd0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic wait_done(input string name, input int maxc);
    for (int i = 0; i < maxc && !done; i++) begin
      @(posedge clk); #1;
    end
    chk_eq(name, 32'(done), 32'd1);
  endtask

  task automatic run_region(input logic [31:0] s, input logic [31:0] e, input logic [31:0] code);
    bus_write(BASE + 32'h4, s, 4'hF);
    bus_write(BASE + 32'h8, e, 4'hF);
    model_arm(s, e);
    bus_write(BASE, code, 4'hF);
  endtask

  task automatic check_nominal(input string tag);
    chk_eq({tag, "_req_count"}, 32'(req_log.size()), 32'd4);
    chk_eq({tag, "_rx_count"}, 32'(rx_log.size()), 32'(4 + HOFF));
    if (req_log.size() == 4) begin
      for (int i = 0; i < 4; i++) chk_eq({tag, "_req_addr"}, 32'(req_log[i]), 32'h40 + 32'(i));
    end
    if (rx_log.size() == 4 + HOFF) begin
      for (int i = 0; i < 4; i++) chk_eq({tag, "_rx_word"}, rx_log[i + HOFF], A[i]);
      chk_eq({tag, "_last_on_A3"}, 32'(last_log[3 + HOFF]), 32'd1);
      chk_eq({tag, "_no_last_on_A2"}, 32'(last_log[2 + HOFF]), 32'd0);
    end
    chk_eq({tag, "_model_drained"}, 32'(exp_words.size() + exp_addrs.size()), 32'd0);
  endtask

  initial begin
    logic [31:0] d;
    bit          found;
    for (int i = 0; i < 4; i++) mem[32'h40 + i] = A[i];

    // Reset state and register readback with byte strobes.
    do_reset(1'b1);
    bus_write(BASE + 32'h4, 32'h1234_5678, 4'hF);
    bus_write(BASE + 32'h4, 32'hDEAD_BEEF, 4'b0011);
    bus_read(BASE + 32'h4, d);
    chk_eq("strb_readback", d, 32'h1234_BEEF);
    bus_write(BASE + 32'hC, 32'hFFFF_FFFF, 4'hF);
    bus_read(BASE + 32'hC, d);
    chk_eq("status_ro", d, 32'd0);

    // Zero TOHOST write: no dump.
    bus_write(BASE, 32'd0, 4'hF);
    repeat (6) begin @(posedge clk); #1; end
    bus_read(BASE + 32'hC, d);
    chk_eq("zero_status", d, 32'd0);
    bus_read(BASE, d);
    chk_eq("zero_tohost", d, 32'd0);
    chk_eq("zero_code", tohost_code, 32'd0);

    // Nominal dump.
    do_reset(1'b0);
    sig_ready = 1'b1;
    run_region(32'h100, 32'h110, 32'd1);
    wait_done("nom_done", 60);
    check_nominal("nom");
    chk_eq("nom_code", tohost_code, 32'd1);
    chk_eq("nom_err", 32'(err), 32'd0);
    bus_read(BASE + 32'hC, d);
    chk_eq("nom_status", d, 32'd2);
    bus_write(BASE, 32'd5, 4'hF);
    repeat (4) begin @(posedge clk); #1; end
    chk_eq("done_terminal_code", tohost_code, 32'd1);

    // Backpressure on word 2.
    do_reset(1'b0);
    run_region(32'h100, 32'h110, 32'd7);
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(posedge clk); #1;
      if (mem_r_en && mem_addr == 26'h42) found = 1'b1;
    end
    chk_eq("bp_reach_word2", 32'(found), 32'd1);
    sig_ready = 1'b0;
    for (int i = 0; i < 10 && !sig_valid; i++) begin
      @(posedge clk); #1;
    end
    chk_eq("bp_stall_data", sig_data, A[2]);
    repeat (5) begin @(posedge clk); #1; end
    chk_eq("bp_still_held", sig_data, A[2]);
    sig_ready = 1'b1;
    wait_done("bp_done", 60);
    check_nominal("bp");
    chk_eq("bp_code", tohost_code, 32'd7);

    // Empty region.
    do_reset(1'b0);
    run_region(32'h200, 32'h200, 32'd1);
    wait_done("empty_done", 20);
    chk_eq("empty_err", 32'(err), 32'd0);
    chk_eq("empty_rx", 32'(rx_log.size()), 32'(HOFF));

    // Inverted region.
    do_reset(1'b0);
    run_region(32'h204, 32'h200, 32'd1);
    wait_done("inv_done", 20);
    chk_eq("inv_err", 32'(err), 32'd1);
    chk_eq("inv_rx", 32'(rx_log.size()), 32'd0);

    // Misaligned start.
    do_reset(1'b0);
    run_region(32'h102, 32'h110, 32'd1);
    wait_done("mis_done", 20);
    chk_eq("mis_err", 32'(err), 32'd1);
    chk_eq("mis_req", 32'(req_log.size()), 32'd0);

    // Reset while word 1 is presented.
    do_reset(1'b0);
    sig_ready = 1'b0;
    run_region(32'h100, 32'h110, 32'd1);
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (sig_valid) sig_ready = 1'b1;
      @(posedge clk); #1;
      sig_ready = 1'b0;
      if (sig_valid && sig_data == A[1]) found = 1'b1;
    end
    chk_eq("mid_reach_word1", 32'(found), 32'd1);
    rst_n = 1'b0;
    model_clear();
    #1;
    chk_eq("mid_valid", 32'(sig_valid), 32'd0);
    chk_eq("mid_done", 32'(done), 32'd0);
    chk_eq("mid_last", 32'(sig_last), 32'd0);
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    sig_ready = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    chk_eq("mid_no_req", 32'(req_log.size()), 32'd0);
    bus_read(BASE + 32'h4, d);
    chk_eq("mid_sig_start", d, 32'd0);
    bus_read(BASE + 32'h8, d);
    chk_eq("mid_sig_end", d, 32'd0);
    bus_read(BASE, d);
    chk_eq("mid_tohost", d, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
